hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 86 ++++++++
 tb/tb_hilo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO register control: latches a multiplier product and commits it to HI/LO
// after MUL_LAT cycles, with MTHI/MTLO writes, MFHI/MFLO reads and a hazard stall.
module hilo_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_mul_start,
    input  logic [31:0] in_mul_hi,
    input  logic [31:0] in_mul_lo,
    input  logic        in_mthi,
    input  logic        in_mtlo,
    input  logic [31:0] in_wdata,
    input  logic        in_mfhi,
    input  logic        in_mflo,
    output logic [31:0] out_rdata,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        out_busy,
    output logic        out_stall
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [2:0] LAT  = 3'(MUL_LAT);

    logic [0:0]  state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [63:0] pending_reg, pending_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            IDLE: begin
                // Moves land now; a multiply issued in the same cycle overwrites them at commit.
                if (in_mthi) hi_next = in_wdata;
                if (in_mtlo) lo_next = in_wdata;
                if (in_mul_start) begin
                    pending_next = {in_mul_hi, in_mul_lo};
                    cnt_next     = LAT;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                // Counter is left at 1 on commit so it never reaches zero outside reset.
                if (cnt_reg == 3'd1) begin
                    hi_next    = pending_reg[63:32];
                    lo_next    = pending_reg[31:0];
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            pending_reg <= 64'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign out_busy  = (state_reg == BUSY);
    assign out_stall = out_busy & (in_mul_start | in_mthi | in_mtlo | in_mfhi | in_mflo);
    assign out_hi    = hi_reg;
    assign out_lo    = lo_reg;
    assign out_rdata = in_mfhi ? hi_reg : (in_mflo ? lo_reg : 32'd0);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-count model of HI/LO behaviour.
module tb_hilo_ctrl;

    localparam int MUL_LAT = 3;

    logic        in_clk;
    logic        in_rst;
    logic        in_mul_start;
    logic [31:0] in_mul_hi;
    logic [31:0] in_mul_lo;
    logic        in_mthi;
    logic        in_mtlo;
    logic [31:0] in_wdata;
    logic        in_mfhi;
    logic        in_mflo;
    logic [31:0] out_rdata;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_busy;
    logic        out_stall;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO plus cycles remaining until commit.
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    int          m_left;

    hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_mul_start(in_mul_start),
        .in_mul_hi(in_mul_hi), .in_mul_lo(in_mul_lo), .in_mthi(in_mthi),
        .in_mtlo(in_mtlo), .in_wdata(in_wdata), .in_mfhi(in_mfhi),
        .in_mflo(in_mflo), .out_rdata(out_rdata), .out_hi(out_hi),
        .out_lo(out_lo), .out_busy(out_busy), .out_stall(out_stall)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic idle_inputs();
        in_rst = 1'b0; in_mul_start = 1'b0; in_mul_hi = '0; in_mul_lo = '0;
        in_mthi = 1'b0; in_mtlo = 1'b0; in_wdata = '0; in_mfhi = 1'b0; in_mflo = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge in_clk);
        if (in_rst) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_pend_hi; m_lo = m_pend_lo;
            end
        end else begin
            if (in_mthi) m_hi = in_wdata;
            if (in_mtlo) m_lo = in_wdata;
            if (in_mul_start) begin
                m_pend_hi = in_mul_hi; m_pend_lo = in_mul_lo; m_left = MUL_LAT;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        #1;
        checks++;
        if (out_hi !== 32'd0 || out_lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", out_hi, out_lo);
        end
        checks++;
        if (out_busy !== 1'b0 || out_rdata !== 32'd0 || out_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b rdata=%h stall=%b want 0/0/0", out_busy, out_rdata, out_stall);
        end
        $display("txn reset: hi=%h lo=%h busy=%b", out_hi, out_lo, out_busy);
    endtask

    task automatic test_issue();
        idle_inputs();
        in_mul_start = 1'b1; in_mul_hi = 32'h0000_0001; in_mul_lo = 32'hFFFF_FFFE;
        tick();
        in_mul_start = 1'b0; in_mflo = 1'b1;
        for (int i = 0; i < MUL_LAT; i++) begin
            #1;
            checks++;
            if (out_busy !== 1'b1 || out_stall !== 1'b1 || out_hi !== 32'd0) begin
                failures++;
                $display("FAIL issue_busy[%0d]: got busy=%b stall=%b hi=%h want 1/1/0", i, out_busy, out_stall, out_hi);
            end
            tick();
        end
        #1;
        checks++;
        if (out_hi !== 32'h0000_0001 || out_lo !== 32'hFFFF_FFFE || out_busy !== 1'b0) begin
            failures++;
            $display("FAIL issue_commit: got hi=%h lo=%h busy=%b want 00000001/fffffffe/0", out_hi, out_lo, out_busy);
        end
        checks++;
        if (out_stall !== 1'b0 || out_rdata !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL issue_hazard: got stall=%b rdata=%h want 0/fffffffe", out_stall, out_rdata);
        end
        $display("txn issue: hi=%h lo=%h rdata=%h", out_hi, out_lo, out_rdata);
        idle_inputs();
    endtask

    task automatic test_moves();
        idle_inputs();
        in_mthi = 1'b1; in_mtlo = 1'b1; in_wdata = 32'h1234_5678;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_hi !== 32'h1234_5678 || out_lo !== 32'h1234_5678) begin
            failures++;
            $display("FAIL move_both: got hi=%h lo=%h want 12345678", out_hi, out_lo);
        end
        in_mthi = 1'b1; in_wdata = 32'hCAFE_F00D;
        tick();
        in_mthi = 1'b0; in_mfhi = 1'b1; in_mflo = 1'b1;
        #1;
        checks++;
        if (out_rdata !== 32'hCAFE_F00D || out_lo !== 32'h1234_5678) begin
            failures++;
            $display("FAIL move_hi_prio: got rdata=%h lo=%h want cafef00d/12345678", out_rdata, out_lo);
        end
        in_mfhi = 1'b0;
        #1;
        checks++;
        if (out_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL move_mflo: got rdata=%h want 12345678", out_rdata);
        end
        // Same-cycle MTLO must not be forwarded to the read port.
        in_mtlo = 1'b1; in_wdata = 32'h0BAD_BEEF;
        #1;
        checks++;
        if (out_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL move_no_fwd: got rdata=%h want 12345678", out_rdata);
        end
        tick();
        $display("txn moves: hi=%h lo=%h", out_hi, out_lo);
        idle_inputs();
    endtask

    task automatic test_abort();
        idle_inputs();
        in_mul_start = 1'b1; in_mul_hi = 32'h5555_5555; in_mul_lo = 32'h6666_6666;
        tick();
        idle_inputs();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        #1;
        checks++;
        if (out_busy !== 1'b0 || out_hi !== 32'd0 || out_lo !== 32'd0) begin
            failures++;
            $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want 0/0/0", out_busy, out_hi, out_lo);
        end
        tick(); tick(); tick();
        checks++;
        if (out_hi !== 32'd0 || out_lo !== 32'd0 || out_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_nocommit: got hi=%h lo=%h busy=%b want 0/0/0", out_hi, out_lo, out_busy);
        end
        $display("txn abort: hi=%h lo=%h busy=%b", out_hi, out_lo, out_busy);
    endtask

    task automatic test_overlap();
        idle_inputs();
        in_mul_start = 1'b1; in_mul_hi = 32'h1111_1111; in_mul_lo = 32'h2222_2222;
        tick();
        in_mul_hi = 32'hAAAA_AAAA; in_mul_lo = 32'hBBBB_BBBB;
        #1;
        checks++;
        if (out_stall !== 1'b1) begin
            failures++;
            $display("FAIL overlap_stall: got stall=%b want 1", out_stall);
        end
        tick();
        in_mul_start = 1'b0; in_mthi = 1'b1; in_mtlo = 1'b1; in_wdata = 32'h7777_7777;
        tick();
        checks++;
        if (out_hi !== 32'd0 || out_lo !== 32'd0) begin
            failures++;
            $display("FAIL overlap_move_ignored: got hi=%h lo=%h want 0/0", out_hi, out_lo);
        end
        in_mthi = 1'b0; in_mtlo = 1'b0;
        tick();
        checks++;
        if (out_hi !== 32'h1111_1111 || out_lo !== 32'h2222_2222 || out_busy !== 1'b0) begin
            failures++;
            $display("FAIL overlap_commit: got hi=%h lo=%h busy=%b want 11111111/22222222/0", out_hi, out_lo, out_busy);
        end
        $display("txn overlap: hi=%h lo=%h", out_hi, out_lo);
        idle_inputs();
    endtask

    task automatic test_mul_with_move();
        idle_inputs();
        in_mul_start = 1'b1; in_mul_hi = 32'h9999_0000; in_mul_lo = 32'h0000_9999;
        in_mthi = 1'b1; in_mtlo = 1'b1; in_wdata = 32'h4242_4242;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_hi !== 32'h4242_4242 || out_lo !== 32'h4242_4242 || out_busy !== 1'b1) begin
            failures++;
            $display("FAIL mulmove_now: got hi=%h lo=%h busy=%b want 42424242/42424242/1", out_hi, out_lo, out_busy);
        end
        for (int i = 0; i < MUL_LAT; i++) tick();
        checks++;
        if (out_hi !== 32'h9999_0000 || out_lo !== 32'h0000_9999) begin
            failures++;
            $display("FAIL mulmove_commit: got hi=%h lo=%h want 99990000/00009999", out_hi, out_lo);
        end
        $display("txn mul_with_move: hi=%h lo=%h", out_hi, out_lo);
    endtask

    task automatic test_random();
        logic [31:0] exp_rdata;
        logic        exp_stall;
        for (int n = 0; n < 400; n++) begin
            in_rst       = ($urandom_range(0, 49) == 0);
            in_mul_start = ($urandom_range(0, 3) == 0);
            in_mul_hi    = $urandom;
            in_mul_lo    = $urandom;
            in_mthi      = ($urandom_range(0, 5) == 0);
            in_mtlo      = ($urandom_range(0, 5) == 0);
            in_wdata     = $urandom;
            in_mfhi      = ($urandom_range(0, 2) == 0);
            in_mflo      = ($urandom_range(0, 2) == 0);
            #1;
            exp_rdata = in_mfhi ? m_hi : (in_mflo ? m_lo : 32'd0);
            exp_stall = (m_left > 0) && (in_mul_start || in_mthi || in_mtlo || in_mfhi || in_mflo);
            checks++;
            if (out_rdata !== exp_rdata || out_stall !== exp_stall) begin
                failures++;
                $display("FAIL rand_comb[%0d]: got rdata=%h stall=%b want %h/%b", n, out_rdata, out_stall, exp_rdata, exp_stall);
            end
            tick();
            checks++;
            if (out_hi !== m_hi || out_lo !== m_lo || out_busy !== (m_left > 0)) begin
                failures++;
                $display("FAIL rand_state[%0d]: got hi=%h lo=%h busy=%b want %h/%h/%b", n, out_hi, out_lo, out_busy, m_hi, m_lo, (m_left > 0));
            end
        end
        $display("txn random: 400 cycles, hi=%h lo=%h", out_hi, out_lo);
        idle_inputs();
    endtask

    initial begin
        m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0; m_left = 0;
        idle_inputs();
        in_rst = 1'b1;
        tick();
        test_reset();
        test_issue();
        test_moves();
        test_abort();
        test_overlap();
        test_mul_with_move();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
